// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/retire slice: op encodings, command
// layout and result width. The command is packed as {a, b, sel}.
package alu_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_e;

  localparam int ALU_CMD_W   = 6;
  localparam int ALU_RES_W   = 3;
  localparam int ALU_SEL_LSB = 0;
  localparam int ALU_B_LSB   = 2;
  localparam int ALU_A_LSB   = 4;

  // Field order matches the offsets above: a in [5:4], b in [3:2], sel in [1:0].
  typedef struct packed {
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] sel;
  } alu_cmd_t;

  // Arithmetic ops report the ALU's top result bit (carry or borrow);
  // logical ops never set the flag.
  function automatic logic alu_flag(input logic [1:0] sel,
                                    input logic [ALU_RES_W-1:0] res);
    return ((sel == ALU_ADD) || (sel == ALU_SUB)) ? res[ALU_RES_W-1] : 1'b0;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with explicit occupancy tracking.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   push_i, wdata_i  write request and data (ignored when full)
//   pop_i            read request (ignored when empty)
//   head_o           entry at the read pointer
//   full_o, empty_o  occupancy flags
//   level_o          number of stored entries, 0..DEPTH
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  // DEPTH is a power of two, so pointers wrap by natural overflow; the
  // separate level counter keeps full and empty distinct.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: contents are only visible through level.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue/retire stage around an external combinational 2-bit ALU.
// Commands {a, b, sel} enter on a valid/ready handshake into a FIFO; the FIFO
// head drives the ALU, and the returned result is captured into an output
// register presented on a second valid/ready handshake.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   in_valid/in_ready/in_a/in_b/in_sel  command input handshake
//   alu_a/alu_b/alu_sel               head command to the ALU (0 when empty)
//   alu_result                        combinational ALU result
//   out_valid/out_ready               result output handshake
//   out_result/out_sel/out_flag       registered result, op tag, carry/borrow
//   level                             FIFO occupancy
//   op_count                          completed output handshakes (wraps)
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_a,
  input  logic [1:0]             in_b,
  input  logic [1:0]             in_sel,
  output logic [1:0]             alu_a,
  output logic [1:0]             alu_b,
  output logic [1:0]             alu_sel,
  input  logic [ALU_RES_W-1:0]   alu_result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ALU_RES_W-1:0]   out_result,
  output logic [1:0]             out_sel,
  output logic                   out_flag,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_W-1:0]       op_count
);

  alu_cmd_t in_cmd, head_cmd;
  logic     fifo_full, fifo_empty;
  logic     push, issue, out_hs;

  logic                 out_valid_q,  out_valid_d;
  logic [ALU_RES_W-1:0] out_result_q, out_result_d;
  logic [1:0]           out_sel_q,    out_sel_d;
  logic                 out_flag_q,   out_flag_d;
  logic [CNT_W-1:0]     op_count_q,   op_count_d;

  assign in_cmd = '{a: in_a, b: in_b, sel: in_sel};

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ALU_CMD_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (in_cmd),
    .pop_i   (issue),
    .head_o  (head_cmd),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  // in_ready deliberately ignores a same-cycle pop so it never depends on out_ready.
  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;
  assign issue    = !fifo_empty && (!out_valid_q || out_ready);
  assign out_hs   = out_valid_q && out_ready;

  assign alu_a   = fifo_empty ? 2'b00 : head_cmd.a;
  assign alu_b   = fifo_empty ? 2'b00 : head_cmd.b;
  assign alu_sel = fifo_empty ? 2'b00 : head_cmd.sel;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_sel_d    = out_sel_q;
    out_flag_d   = out_flag_q;
    op_count_d   = op_count_q;
    if (issue) begin
      out_valid_d  = 1'b1;
      out_result_d = alu_result;
      out_sel_d    = head_cmd.sel;
      out_flag_d   = alu_flag(head_cmd.sel, alu_result);
    end else if (out_hs) begin
      out_valid_d  = 1'b0;
    end
    if (out_hs) op_count_d = op_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_sel_q    <= '0;
      out_flag_q   <= 1'b0;
      op_count_q   <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_sel_q    <= out_sel_d;
      out_flag_q   <= out_flag_d;
      op_count_q   <= op_count_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_sel    = out_sel_q;
  assign out_flag   = out_flag_q;
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, in_valid, out_ready;
  logic [1:0] in_a, in_b, in_sel;

  logic       in_ready, out_valid, out_flag;
  logic [1:0] alu_a, alu_b, alu_sel, out_sel;
  logic [2:0] alu_result, out_result, level;
  logic [7:0] op_count;

  logic       w_in_ready, w_out_valid, w_out_flag;
  logic [1:0] w_alu_a, w_alu_b, w_alu_sel, w_out_sel;
  logic [2:0] w_alu_result, w_out_result, w_level;
  logic [3:0] w_op_count;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [2:0] alu_model(input logic [1:0] a, input logic [1:0] b,
                                           input logic [1:0] sel);
    case (sel)
      2'b00:   return {1'b0, a} + {1'b0, b};
      2'b01:   return {1'b0, a} - {1'b0, b};
      2'b10:   return {1'b0, a & b};
      default: return {1'b0, a | b};
    endcase
  endfunction

  assign alu_result   = alu_model(alu_a, alu_b, alu_sel);
  assign w_alu_result = alu_model(w_alu_a, w_alu_b, w_alu_sel);

  alu_issue_stage #(.DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sel(in_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_sel(out_sel), .out_flag(out_flag), .level(level), .op_count(op_count)
  );

  alu_issue_stage #(.DEPTH(4), .CNT_W(4)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_a(in_a), .in_b(in_b), .in_sel(in_sel),
    .alu_a(w_alu_a), .alu_b(w_alu_b), .alu_sel(w_alu_sel), .alu_result(w_alu_result),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_result(w_out_result),
    .out_sel(w_out_sel), .out_flag(w_out_flag), .level(w_level), .op_count(w_op_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = 2'd0; in_b = 2'd0; in_sel = 2'd0;
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", level); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    tick();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_a = 2'(i); in_b = 2'd1; in_sel = 2'b10;
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (level !== 3'd3) begin n_fail++; $display("FAIL pre_reset_level: got %0d want 3", level); end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_out_valid: got %b want 1", out_valid); end
    tick();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL mid_reset_level: got %0d want 0", level); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (op_count !== 8'd0 || w_op_count !== 4'd0) begin n_fail++; $display("FAIL mid_reset_op_count: got %0d/%0d want 0/0", op_count, w_op_count); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_in_ready: got %b want 1", in_ready); end
    n_checks++; if ({alu_a, alu_b, alu_sel} !== 6'd0) begin n_fail++; $display("FAIL mid_reset_alu: got %b want 000000", {alu_a, alu_b, alu_sel}); end
    n_checks++; if ({out_result, out_sel, out_flag} !== 6'd0) begin n_fail++; $display("FAIL mid_reset_out_regs: got %b want 000000", {out_result, out_sel, out_flag}); end
  endtask

  task automatic test_single_add();
    tick();
    out_ready = 1'b1; in_valid = 1'b1; in_a = 2'd3; in_b = 2'd3; in_sel = 2'b00;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_c0_valid: got %b want 0", out_valid); end
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_c1_valid: got %b want 0", out_valid); end
    n_checks++; if (level !== 3'd1) begin n_fail++; $display("FAIL add_c1_level: got %0d want 1", level); end
    n_checks++; if ({alu_a, alu_b, alu_sel} !== 6'b111100) begin n_fail++; $display("FAIL add_c1_alu: got %b want 111100", {alu_a, alu_b, alu_sel}); end
    tick();
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_c2_valid: got %b want 1", out_valid); end
    n_checks++; if (out_result !== 3'b110) begin n_fail++; $display("FAIL add_result: got %b want 110", out_result); end
    n_checks++; if (out_flag !== 1'b1) begin n_fail++; $display("FAIL add_flag: got %b want 1", out_flag); end
    n_checks++; if (out_sel !== 2'b00) begin n_fail++; $display("FAIL add_sel: got %b want 00", out_sel); end
    tick();
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_c3_valid: got %b want 0", out_valid); end
    n_checks++; if (op_count !== 8'd1) begin n_fail++; $display("FAIL add_op_count: got %0d want 1", op_count); end
  endtask

  task automatic test_ops_in_order();
    logic [1:0] va [3] = '{2'd1, 2'd3, 2'd1};
    logic [1:0] vb [3] = '{2'd2, 2'd2, 2'd2};
    logic [1:0] vs [3] = '{2'b01, 2'b10, 2'b11};
    logic [2:0] er [3] = '{3'b111, 3'b010, 3'b011};
    logic       ef [3] = '{1'b1, 1'b0, 1'b0};
    int k = 0;
    tick();
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (cyc < 3) begin
        in_valid = 1'b1; in_a = va[cyc]; in_b = vb[cyc]; in_sel = vs[cyc];
      end else in_valid = 1'b0;
      @(negedge clk);
      if (out_valid) begin
        if (k < 3) begin
          n_checks++; if (out_result !== er[k] || out_flag !== ef[k] || out_sel !== vs[k]) begin
            n_fail++; $display("FAIL ops_result[%0d]: got r=%b f=%b s=%b want r=%b f=%b s=%b", k, out_result, out_flag, out_sel, er[k], ef[k], vs[k]);
          end
          n_checks++; if (cyc != k + 2) begin n_fail++; $display("FAIL ops_timing[%0d]: got cycle %0d want %0d", k, cyc, k + 2); end
        end else begin
          n_checks++; n_fail++; $display("FAIL ops_extra: got result %b want none", out_result);
        end
        k++;
      end
      tick();
    end
    n_checks++; if (k != 3) begin n_fail++; $display("FAIL ops_count: got %0d results want 3", k); end
    n_checks++; if (op_count !== 8'd4) begin n_fail++; $display("FAIL ops_op_count: got %0d want 4", op_count); end
  endtask

  task automatic test_backpressure();
    logic [1:0] va [5] = '{2'd0, 2'd3, 2'd2, 2'd1, 2'd2};
    logic [1:0] vb [5] = '{2'd1, 2'd1, 2'd3, 2'd1, 2'd2};
    logic [1:0] vs [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
    logic [2:0] er [5] = '{3'b001, 3'b010, 3'b010, 3'b001, 3'b100};
    logic       ef [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int k = 0;
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_a = va[i]; in_b = vb[i]; in_sel = vs[i];
      tick();
    end
    in_a = 2'd3; in_b = 2'd3; in_sel = 2'b01;
    @(negedge clk);
    n_checks++; if (level !== 3'd4) begin n_fail++; $display("FAIL bp_level: got %0d want 4", level); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
    n_checks++; if (out_valid !== 1'b1 || out_result !== 3'b001 || out_sel !== 2'b00) begin
      n_fail++; $display("FAIL bp_head_out: got v=%b r=%b s=%b want v=1 r=001 s=00", out_valid, out_result, out_sel);
    end
    tick();
    @(negedge clk);
    n_checks++; if (level !== 3'd4 || out_result !== 3'b001 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_hold: got lvl=%0d v=%b r=%b want lvl=4 v=1 r=001", level, out_valid, out_result);
    end
    tick();
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_pop_ready: got %b want 0", in_ready); end
      end
      if (out_valid) begin
        if (k < 5) begin
          n_checks++; if (out_result !== er[k] || out_flag !== ef[k] || out_sel !== vs[k]) begin
            n_fail++; $display("FAIL bp_result[%0d]: got r=%b f=%b s=%b want r=%b f=%b s=%b", k, out_result, out_flag, out_sel, er[k], ef[k], vs[k]);
          end
          n_checks++; if (cyc != k) begin n_fail++; $display("FAIL bp_timing[%0d]: got cycle %0d want %0d", k, cyc, k); end
        end else begin
          n_checks++; n_fail++; $display("FAIL bp_extra: got result %b want none", out_result);
        end
        k++;
      end
      tick();
      if (cyc == 0) begin
        in_valid = 1'b0;
        n_checks++; if (level !== 3'd3) begin n_fail++; $display("FAIL bp_full_push_refused: got level %0d want 3", level); end
      end
    end
    n_checks++; if (k != 5) begin n_fail++; $display("FAIL bp_count: got %0d results want 5", k); end
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL bp_drained: got level %0d want 0", level); end
    n_checks++; if (op_count !== 8'd9) begin n_fail++; $display("FAIL bp_op_count: got %0d want 9", op_count); end
  endtask

  task automatic test_streaming();
    logic [1:0] ea [20];
    logic [1:0] eb [20];
    logic [1:0] es [20];
    int k = 0;
    do_reset();
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (cyc < 20) begin
        ea[cyc] = 2'(cyc % 4); eb[cyc] = 2'((cyc / 4) % 4); es[cyc] = 2'((cyc / 2) % 4);
        in_valid = 1'b1; in_a = ea[cyc]; in_b = eb[cyc]; in_sel = es[cyc];
      end else in_valid = 1'b0;
      @(negedge clk);
      n_checks++; if (level > 3'd1) begin n_fail++; $display("FAIL stream_level @%0d: got %0d want <=1", cyc, level); end
      if (out_valid) begin
        if (k < 20) begin
          n_checks++; if (out_result !== alu_model(ea[k], eb[k], es[k]) || out_sel !== es[k] || cyc != k + 2) begin
            n_fail++; $display("FAIL stream_result[%0d]: got r=%b s=%b cyc=%0d want r=%b s=%b cyc=%0d", k, out_result, out_sel, cyc, alu_model(ea[k], eb[k], es[k]), es[k], k + 2);
          end
        end else begin
          n_checks++; n_fail++; $display("FAIL stream_extra: got result %b want none", out_result);
        end
        k++;
      end
      tick();
    end
    n_checks++; if (k != 20) begin n_fail++; $display("FAIL stream_count: got %0d results want 20", k); end
    n_checks++; if (op_count !== 8'd20) begin n_fail++; $display("FAIL stream_op_count: got %0d want 20", op_count); end
  endtask

  task automatic test_counter_wrap();
    do_reset();
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 25; cyc++) begin
      if (cyc < 17) begin
        in_valid = 1'b1; in_a = 2'(cyc % 4); in_b = 2'd1; in_sel = 2'b11;
      end else in_valid = 1'b0;
      tick();
    end
    @(negedge clk);
    n_checks++; if (w_op_count !== 4'd1) begin n_fail++; $display("FAIL wrap_op_count4: got %0d want 1", w_op_count); end
    n_checks++; if (op_count !== 8'd17) begin n_fail++; $display("FAIL wrap_op_count8: got %0d want 17", op_count); end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_ops_in_order();
    test_backpressure();
    test_streaming();
    test_counter_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Issue and retire stage wrapped around the 2-bit combinational ALU.
- Accepts {A, B, sel} commands on a valid/ready handshake and buffers them in a small FIFO.
- Drives the head command onto the ALU operand/select ports and registers the returned 3-bit result.
- Presents the result downstream on a valid/ready handshake, with a flag bit and a completed-operation counter.

Parameters:
- DEPTH, 4, command FIFO entries (power of 2, at least 2).
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  command valid.
- in_ready  out  1  command accepted when in_valid && in_ready.
- in_a  in  2  operand A.
- in_b  in  2  operand B.
- in_sel  in  2  op: 00 add, 01 sub, 10 and, 11 or.
- alu_a  out  2  operand A to the ALU (combinational from FIFO head).
- alu_b  out  2  operand B to the ALU.
- alu_sel  out  2  op select to the ALU.
- alu_result  in  3  combinational result returned by the ALU.
- out_valid  out  1  result register holds a result.
- out_ready  in  1  downstream accepts the result.
- out_result  out  3  registered ALU result.
- out_sel  out  2  op tag of out_result.
- out_flag  out  1  add: carry (result[2]); sub: borrow (result[2]); and/or: 0.
- level  out  clog2(DEPTH)+1  FIFO occupancy.
- op_count  out  CNT_W  completed output handshakes, wraps modulo 2^CNT_W.

Behaviour:
- Reset (sync, active-high, dominates all other events):
  - FIFO pointers and level go to 0.
  - out_valid, out_result, out_sel, out_flag and op_count go to 0.
  - in_ready is 1 after reset.
  - Any in-flight command is discarded.
- Push:
  - in_ready = (level != DEPTH). It does not look ahead to a same-cycle pop.
  - On an accepted handshake, {in_a, in_b, in_sel} is written at the FIFO tail.
- ALU drive:
  - When level != 0, alu_a/alu_b/alu_sel = head entry.
  - When the FIFO is empty, they are driven to 0.
- Issue condition: issue = (level != 0) && (!out_valid || out_ready).
- On issue, at the clock edge:
  - The head is popped.
  - out_result <= alu_result and out_sel <= head sel.
  - out_flag <= alu_result[2] if sel is 00 or 01, else 0.
  - out_valid <= 1.
- Output handshake:
  - out_valid && out_ready with no issue in the same cycle: out_valid <= 0.
  - With a simultaneous issue, the register reloads and out_valid stays 1.
  - out_result/out_sel/out_flag hold stable while out_valid && !out_ready.
- op_count increments by 1 on every output handshake and wraps from 2^CNT_W-1 to 0.
- Latency and throughput:
  - A command handshaken in cycle c appears on out_valid in cycle c+2 at the earliest.
  - Sustained throughput is 1 result per cycle when out_ready is held high.
- Simultaneous push and pop:
  - Allowed when not full; level is unchanged.
  - At full, push is refused even if a pop occurs that cycle.
- Wrap-around:
  - Read and write pointers wrap modulo DEPTH.
  - level is tracked explicitly (or via an extra pointer bit) so full and empty are distinguishable.
- Arithmetic is the ALU's 3-bit modulo result:
  - sub 1-2 gives 3'b111.
  - add 3+3 gives 3'b110.
- The stage never modifies the ALU result; it only registers it.
- Backpressure: with out_ready low, the FIFO fills to DEPTH and in_ready drops. Commands are never lost or reordered.

Decomposition:
- Shared package alu_pkg:
  - Op encodings ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_AND=2'b10, ALU_OR=2'b11.
  - Command width constant ALU_CMD_W=6.
  - Result width ALU_RES_W=3.
  - Field offsets for the packed {a, b, sel} command.
- Sub-module alu_cmd_fifo:
  - Synchronous FIFO, parameterised DEPTH and width.
  - Ports: push, pop, full, empty, level, head data.
- The top level holds the issue logic, the result register and the counter. The ALU itself is instantiated outside the block.

Test Plan:
- Reset mid-stream: with 3 commands queued and out_valid=1, assert rst for 1 cycle → next cycle level=0, out_valid=0, op_count=0, in_ready=1, alu_a/b/sel=0.
- Single add, ALU model attached: a=3, b=3, sel=00, out_ready=1 → out_valid in cycle c+2, out_result=3'b110, out_flag=1, out_sel=00, op_count=1.
- Sub underflow: a=1, b=2, sel=01 → out_result=3'b111, out_flag=1. Then and a=3, b=2 → 3'b010, out_flag=0. Then or a=1, b=2 → 3'b011, out_flag=0. All results arrive in order.
- Backpressure to full: out_ready=0, push 5 commands with DEPTH=4 → first issues to the output register, 4 fill the FIFO, level=4, in_ready=0. Output holds stable. Release out_ready → all 5 results drain in order, one per cycle.
- Streaming: 20 back-to-back commands with in_valid=1 and out_ready=1 → 20 results on consecutive cycles after the 2-cycle fill, level never exceeds 1, op_count=20.
- Counter wrap with CNT_W=4: 17 completed handshakes → op_count=1.
